// File: rtl/round_robin_encoder_pkg.sv
// Shared constants and state type for the round-robin 4:2 encoder.
package round_robin_encoder_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        RR_IDLE  = 1'b0,
        RR_GRANT = 1'b1
    } rr_state_t;

endpackage : round_robin_encoder_pkg

// File: rtl/rotating_priority_pick_4.sv
// Combinational rotating-priority search: first asserted request at or after
// start_i in wrap order, optionally ignoring one index.
module rotating_priority_pick_4
    import round_robin_encoder_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    input  logic               excl_en_i,
    input  logic [IDX_W-1:0]   excl_idx_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    logic [NUM_REQ-1:0] masked;
    logic [IDX_W-1:0]   cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        masked = req_i;
        if (excl_en_i) begin
            masked[excl_idx_i] = 1'b0;
        end
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = start_i + IDX_W'(i);
            if (masked[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule : rotating_priority_pick_4

// File: rtl/round_robin_encoder_4_2.sv
// Four-requester round-robin arbiter producing a registered 2-bit grant index
// with a valid/ready handshake toward the downstream 2-4 decoder.
module round_robin_encoder_4_2
    import round_robin_encoder_pkg::*;
(
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Request_0_In,
    input  logic             Request_1_In,
    input  logic             Request_2_In,
    input  logic             Request_3_In,
    input  logic             Ready_In,
    output logic [IDX_W-1:0] Encoded_Value_Out,
    output logic             Valid_Out,
    output logic [IDX_W-1:0] Pointer_Out
);

    rr_state_t          state_q;
    logic [IDX_W-1:0]   enc_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] req_vec;
    logic [IDX_W-1:0]   pick_start;
    logic               pick_excl_en;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    assign req_vec = {Request_3_In, Request_2_In, Request_1_In, Request_0_In};

    // Pointer that a handshake on the current grant would install.
    assign ptr_d = enc_q + IDX_W'(1);

    // While granting, the search previews the post-handshake pointer and
    // skips the index being accepted; when idle it uses the live pointer.
    assign pick_start   = (state_q == RR_GRANT) ? ptr_d : ptr_q;
    assign pick_excl_en = (state_q == RR_GRANT);

    rotating_priority_pick_4 u_pick (
        .req_i      (req_vec),
        .start_i    (pick_start),
        .excl_en_i  (pick_excl_en),
        .excl_idx_i (enc_q),
        .idx_o      (pick_idx),
        .found_o    (pick_found)
    );

    // Arbitration state, grant index and priority pointer.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= RR_IDLE;
            enc_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                RR_IDLE: begin
                    if (pick_found) begin
                        enc_q   <= pick_idx;
                        state_q <= RR_GRANT;
                    end
                end
                RR_GRANT: begin
                    if (Ready_In) begin
                        ptr_q <= ptr_d;
                        if (pick_found) begin
                            enc_q <= pick_idx;
                        end else begin
                            state_q <= RR_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= RR_IDLE;
                end
            endcase
        end
    end

    assign Encoded_Value_Out = enc_q;
    assign Valid_Out         = (state_q == RR_GRANT);
    assign Pointer_Out       = ptr_q;

endmodule : round_robin_encoder_4_2

// File: tb/tb_round_robin_encoder_4_2.sv
// Directed + random bench for round_robin_encoder_4_2 with a scoreboard fed
// by an independent arbitration model.
module tb_round_robin_encoder_4_2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] enc_o;
    logic       valid_o;
    logic [1:0] ptr_o;

    always #5 clk = ~clk;

    round_robin_encoder_4_2 dut (
        .Clock_In          (clk),
        .Reset_In          (rst),
        .Request_0_In      (req[0]),
        .Request_1_In      (req[1]),
        .Request_2_In      (req[2]),
        .Request_3_In      (req[3]),
        .Ready_In          (rdy),
        .Encoded_Value_Out (enc_o),
        .Valid_Out         (valid_o),
        .Pointer_Out       (ptr_o)
    );

    typedef struct packed {
        logic       v;
        logic [1:0] e;
        logic [1:0] p;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic       m_valid;
    logic [1:0] m_enc;
    logic [1:0] m_ptr;

    // Downstream 2-4 decoder: one strobe per live grant.
    logic [3:0] dec;
    assign dec = valid_o ? (4'b0001 << enc_o) : 4'b0000;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Returns {found, idx}; scans start, start+1, ... mod 4, skipping ex if enabled.
    function automatic logic [2:0] ref_pick(input logic [3:0] r, input logic [1:0] start,
                                            input logic ex_en, input logic [1:0] ex);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (int'(start) + k) % 4;
            if (r[c] && !(ex_en && (c == int'(ex)))) return {1'b1, 2'(c)};
        end
        return 3'b000;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rd);
        logic [2:0] p;
        logic [1:0] old_enc;
        if (!m_valid) begin
            p = ref_pick(r, m_ptr, 1'b0, 2'd0);
            if (p[2]) begin
                m_valid = 1'b1;
                m_enc   = p[1:0];
            end
        end else if (rd) begin
            old_enc = m_enc;
            m_ptr   = old_enc + 2'd1;
            p       = ref_pick(r, m_ptr, 1'b1, old_enc);
            if (p[2]) m_enc = p[1:0];
            else      m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic rd);
        exp_t e;
        req = r;
        rdy = rd;
        model_step(r, rd);
        sb.push_back(exp_t'{v: m_valid, e: m_enc, p: m_ptr});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("valid",  4'(valid_o), 4'(e.v));
        chk("index",  4'(enc_o),   4'(e.e));
        chk("ptr",    4'(ptr_o),   4'(e.p));
        chk("decode", dec, e.v ? (4'b0001 << e.e) : 4'b0000);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        req = 4'b0000;
        rdy = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_valid", 4'(valid_o), 4'h0);
        chk("rst_index", 4'(enc_o),   4'h0);
        chk("rst_ptr",   4'(ptr_o),   4'h0);
        m_valid = 1'b0;
        m_enc   = 2'd0;
        m_ptr   = 2'd0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] fair [6];
        fair = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b0;
        req = 4'b0000;
        rdy = 1'b0;
        #1;
        do_reset();

        // Single request on line 2.
        cycle(4'b0100, 1'b1);
        chk("single_idx", 4'(enc_o), 4'd2);
        chk("single_vld", 4'(valid_o), 4'd1);
        cycle(4'b0000, 1'b1);
        chk("single_ptr", 4'(ptr_o), 4'd3);

        // Fairness with all lines high from pointer 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 1'b1);
            chk("fair_seq", 4'(enc_o), 4'(fair[i]));
        end

        // Backpressure on grant 1 with toggling requests.
        do_reset();
        cycle(4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'($urandom), 1'b0);
            chk("bp_idx", 4'(enc_o), 4'd1);
            chk("bp_vld", 4'(valid_o), 4'd1);
        end
        cycle(4'b1101, 1'b1);
        chk("bp_next", 4'(enc_o), 4'd2);

        // Wrap-around from pointer 3.
        do_reset();
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b1);
        chk("wrap_ptr3", 4'(ptr_o), 4'd3);
        cycle(4'b1001, 1'b0);
        chk("wrap_g3", 4'(enc_o), 4'd3);
        cycle(4'b1001, 1'b1);
        chk("wrap_g0", 4'(enc_o), 4'd0);
        chk("wrap_ptr0", 4'(ptr_o), 4'd0);
        cycle(4'b0001, 1'b1);
        chk("wrap_ptr1", 4'(ptr_o), 4'd1);
        chk("wrap_idle", 4'(valid_o), 4'd0);

        // Random traffic through the decoder.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset asserted while grant 2 is live.
        do_reset();
        cycle(4'b0100, 1'b0);
        chk("pre_rst_idx", 4'(enc_o), 4'd2);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_round_robin_encoder_4_2

// File: doc/round_robin_encoder_4_2.md
# round_robin_encoder_4_2

Four-requester round-robin arbiter that compresses one-hot-style request lines into a registered 2-bit grant index with a valid/ready handshake. It sits directly upstream of the 2-4 decoder: `Encoded_Value_Out` drives the decoder's `Encoded_Value_In`, and the decoder's `Data_n_Out` lines become per-requester grant strobes. Fairness is guaranteed by a rotating priority pointer, so no requester waits more than three grants.

## Interface
- `NUM_REQ`, 4: number of requesters; fixed at 4, present for documentation only.
- `IDX_W`, 2: width of the encoded index, equal to clog2(`NUM_REQ`).
- `Clock_In`  in  1  single clock for the block; all state updates on its rising edge.
- `Reset_In`  in  1  asynchronous, active-high reset.
- `Request_0_In` … `Request_3_In`  in  1 each  level requests; a requester holds its line high until its grant is accepted downstream.
- `Ready_In`  in  1  downstream (decoder consumer) accepts the current grant.
- `Encoded_Value_Out`  out  2  registered index of the granted requester.
- `Valid_Out`  out  1  `Encoded_Value_Out` holds a live grant.
- `Pointer_Out`  out  2  current highest-priority requester index, for debug and verification.

## Operation
- Two states: IDLE (`Valid_Out` = 0) and GRANT (`Valid_Out` = 1).
- Arbitration is a search of the requests starting at `Pointer_Out`, then `Pointer_Out`+1, and so on, with all index arithmetic mod 4 and 2-bit wrap (3+1 = 0). The first asserted request wins.
- IDLE: if any request is high, register the winner into `Encoded_Value_Out` and go to GRANT. If no request is high, stay in IDLE; `Encoded_Value_Out` holds its last value.
- GRANT with `Ready_In` = 0: `Encoded_Value_Out`, `Valid_Out` and the pointer are frozen, even if requests change. A request dropped while waiting does not cancel the grant.
- GRANT with `Ready_In` = 1 (handshake): the pointer becomes the accepted index + 1 (mod 4). In the same edge, arbitration is re-run with the new pointer, excluding the just-accepted index. If another request is high, load the new winner and stay in GRANT. Otherwise go to IDLE.
- A request that is still high after its own acceptance is considered again only once its turn returns under the new pointer.
- Requests are sampled only at arbitration edges. Between edges they are don't-care to the outputs.
- The pointer changes only on a handshake, never on reset release or while idle.

## Timing
- Reset values:
  - `Valid_Out` = 0
  - `Encoded_Value_Out` = 2'b00
  - `Pointer_Out` = 2'b00
  - state = IDLE
- Reset acts asynchronously, and mid-grant it clears everything immediately with no handshake completion.
- Latency: a request seen high at edge N in IDLE produces `Valid_Out` = 1 after edge N, i.e. 1 cycle.
- Back-to-back: with continuous requests and `Ready_In` held at 1, one grant is accepted every cycle with no bubble.
- Simultaneous events:
  - A handshake and new request arrivals in the same cycle are arbitrated together at that edge.
  - Requests asserted in the same cycle as reset deassertion are seen at the first following edge.
- Outputs are purely registered, with no combinational path from inputs to outputs.

## Structure
- Package `round_robin_encoder_pkg`:
  - state typedef `rr_state_t` {RR_IDLE, RR_GRANT}
  - `NUM_REQ` and `IDX_W` constants
- Sub-module `rotating_priority_pick_4` (combinational):
  - Inputs: 4-bit request vector, 2-bit start pointer, 1-bit exclude-enable plus 2-bit exclude index.
  - Outputs: 2-bit winner index and `found` flag.
  - Instantiated once in the parent.
- The parent holds the state register, output registers and pointer register.

## Test plan
- Reset: assert `Reset_In` mid-GRANT with `Encoded_Value_Out` = 2 → `Valid_Out` = 0, index = 0 and pointer = 0 immediately, without waiting for a clock edge.
- Single request: only `Request_2_In` high, `Ready_In` = 1 → `Valid_Out` rises 1 cycle later with index 2; after acceptance, pointer = 3.
- Fairness: all four requests held high, `Ready_In` = 1, pointer 0 → grant sequence 0,1,2,3,0,1 on consecutive cycles with no gaps.
- Backpressure: grant 1 live, `Ready_In` = 0 for 5 cycles while requests toggle → index stays 1 and `Valid_Out` stays 1. On `Ready_In` = 1, the next grant is the lowest active index at or after 2 in wrap order.
- Wrap-around: pointer 3, requests 0 and 3 high → grant 3, then 0, with the pointer going 3→0→1.
- Decoder chain: connect to the 2-4 decoder and drive random requests → exactly one `Data_n_Out` high per accepted grant, matching the requester that was granted.
